// File: rtl/alu_slice_sequencer_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
package alu_slice_sequencer_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Function controls held for the whole multi-cycle operation
  typedef struct packed {
    logic [SLICE_W-1:0] select;
    logic               mode;
  } ctrl_t;

  localparam logic [3:0] SEL_ADD = 4'b1001;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_AND = 4'b1011;
  localparam logic [3:0] SEL_XOR = 4'b0110;

endpackage

// File: rtl/alu_slice_sequencer_if.sv
// Request/result bundle between a datapath master and the slice sequencer.
interface alu_slice_sequencer_if
  import alu_slice_sequencer_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) ();

  localparam int unsigned W = SLICE_W * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   select;
  logic         mode;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         zero;

  modport master (
    output start, a, b, select, mode, cin,
    input  busy, done, result, cout, zero
  );

  modport slave (
    input  start, a, b, select, mode, cin,
    output busy, done, result, cout, zero
  );

endinterface

// File: rtl/alu_slice_sequencer_dm74ls181.sv
// DM74LS181 4-bit ALU slice, active-high data; cn and cn4 are active-low carries.
module alu_slice_sequencer_dm74ls181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4
);

  logic [3:0] x_n;
  logic [3:0] y_n;
  logic [4:0] c;

  assign y_n = ~(a | (b & {4{s[0]}}) | (~b & {4{s[1]}}));
  assign x_n = ~((a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}}));

  // Internal ripple runs regardless of m; m only masks it from f
  always_comb begin
    c    = '0;
    f    = '0;
    c[0] = ~cn;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = ~x_n[i] | (~y_n[i] & c[i]);
      f[i]   = (x_n[i] ^ y_n[i]) ^ (m | c[i]);
    end
    cn4 = ~c[4];
  end

endmodule

// File: rtl/alu_slice_sequencer.sv
// Wide ALU built by stepping one 74181 slice across the operands, LSB nibble first.
module alu_slice_sequencer
  import alu_slice_sequencer_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_slice_sequencer_if.slave bus
);

  localparam int unsigned W        = SLICE_W * NIBBLES;
  localparam int unsigned IDX_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_e             state_q,  state_d;
  logic [IDX_W-1:0]   idx_q,    idx_d;
  logic [W-1:0]       a_q,      a_d;
  logic [W-1:0]       b_q,      b_d;
  ctrl_t              ctrl_q,   ctrl_d;
  logic               carry_q,  carry_d;
  logic [W-1:0]       result_q, result_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic               cout_q,   cout_d;
  logic               zero_q,   zero_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_f;
  logic               slice_cn4;

  assign slice_a = a_q[SLICE_W*idx_q +: SLICE_W];
  assign slice_b = b_q[SLICE_W*idx_q +: SLICE_W];

  alu_slice_sequencer_dm74ls181 u_slice (
    .a   (slice_a),
    .b   (slice_b),
    .s   (ctrl_q.select),
    .m   (ctrl_q.mode),
    .cn  (carry_q),
    .f   (slice_f),
    .cn4 (slice_cn4)
  );

  // Next-state: accept in IDLE/DONE, one nibble per RUN cycle
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    ctrl_d   = ctrl_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d       = ST_RUN;
          idx_d         = '0;
          a_d           = bus.a;
          b_d           = bus.b;
          ctrl_d.select = bus.select;
          ctrl_d.mode   = bus.mode;
          carry_d       = bus.cin;
          busy_d        = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        result_d[SLICE_W*idx_q +: SLICE_W] = slice_f;
        carry_d = slice_cn4;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          cout_d  = slice_cn4;
          zero_d  = (result_d == '0);
        end else begin
          busy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ctrl_q   <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctrl_q   <= ctrl_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_slice_sequencer.sv
// Bench for alu_slice_sequencer: wide-arithmetic reference model plus directed vectors.
module tb_alu_slice_sequencer;
  import alu_slice_sequencer_pkg::*;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_slice_sequencer_if #(.NIBBLES(NIB)) bus ();

  alu_slice_sequencer #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Whole-word 74181 function: F = P + G + carry (arith) or ~(P ^ G) (logic)
  function automatic logic [W:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] s, input logic m, input logic cin);
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic [W:0]   sum;
    p   = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    g   = (a & b & {W{s[3]}}) | (a & ~b & {W{s[2]}});
    sum = {1'b0, p} + {1'b0, g} + (W+1)'(!cin);
    return {~sum[W], (m ? ~(p ^ g) : sum[W-1:0])};
  endfunction

  // Transaction-level model: operation takes NIB cycles once accepted
  int           m_rem;
  logic         m_done;
  logic [W-1:0] m_res;
  logic         m_cout;
  logic         m_zero;
  logic [W:0]   m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_res  = '0;
      m_cout = 1'b0;
      m_zero = 1'b0;
      m_pend = '0;
    end else begin
      m_done = 1'b0;
      if (m_rem == 0) begin
        if (bus.start === 1'b1) begin
          m_pend = ref_alu(bus.a, bus.b, bus.select, bus.mode, bus.cin);
          m_rem  = NIB;
        end
      end else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          m_done = 1'b1;
          m_res  = m_pend[W-1:0];
          m_cout = m_pend[W];
          m_zero = (m_pend[W-1:0] == '0);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_busy", 64'(bus.busy), 64'(m_rem > 0));
    check("cmp_done", 64'(bus.done), 64'(m_done));
    if (m_rem == 0) begin
      check("cmp_result", 64'(bus.result), 64'(m_res));
      check("cmp_cout",   64'(bus.cout),   64'(m_cout));
      check("cmp_zero",   64'(bus.zero),   64'(m_zero));
    end
  end

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] s, input logic m, input logic cin);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.select = s; bus.mode = m; bus.cin = cin;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 40) check("done_timeout", 64'(bus.done), 64'(1));
  endtask

  task automatic expect_op(input string name, input int lat, input logic [W-1:0] res,
                           input logic cout, input logic zero);
    check({name, "_latency"}, 64'(lat), 64'(NIB));
    check({name, "_result"}, 64'(bus.result), 64'(res));
    check({name, "_cout"}, 64'(bus.cout), 64'(cout));
    check({name, "_zero"}, 64'(bus.zero), 64'(zero));
  endtask

  int lat;
  int lat2;
  int done_seen;

  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.select = '0; bus.mode = 1'b0; bus.cin = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_busy",   64'(bus.busy),   64'(0));
    check("rst_done",   64'(bus.done),   64'(0));
    check("rst_result", 64'(bus.result), 64'(0));
    check("rst_cout",   64'(bus.cout),   64'(0));
    check("rst_zero",   64'(bus.zero),   64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Pin the reference model against hand-worked values
    check("model_add", 64'(ref_alu(16'h00FF, 16'h0001, SEL_ADD, 1'b0, 1'b1)), 64'({1'b1, 16'h0100}));
    check("model_sub", 64'(ref_alu(16'h0005, 16'h0003, SEL_SUB, 1'b0, 1'b0)), 64'({1'b0, 16'h0002}));
    check("model_and", 64'(ref_alu(16'hF0F0, 16'h3C3C, SEL_AND, 1'b1, 1'b1)), 64'({1'b0, 16'h3030}));
    check("model_xor", 64'(ref_alu(16'hABCD, 16'hABCD, SEL_XOR, 1'b1, 1'b1)), 64'({1'b1, 16'h0000}));

    launch(16'h00FF, 16'h0001, SEL_ADD, 1'b0, 1'b1);
    wait_done(lat);
    expect_op("add_ripple", lat, 16'h0100, 1'b1, 1'b0);

    launch(16'h0005, 16'h0003, SEL_SUB, 1'b0, 1'b0);
    wait_done(lat);
    expect_op("sub_cin0", lat, 16'h0002, 1'b0, 1'b0);

    launch(16'h0005, 16'h0003, SEL_SUB, 1'b0, 1'b1);
    wait_done(lat);
    expect_op("sub_cin1", lat, 16'h0001, 1'b0, 1'b0);

    launch(16'hF0F0, 16'h3C3C, SEL_AND, 1'b1, 1'b1);
    wait_done(lat);
    expect_op("logic_and", lat, 16'h3030, 1'b0, 1'b0);

    launch(16'hABCD, 16'hABCD, SEL_XOR, 1'b1, 1'b1);
    wait_done(lat);
    expect_op("logic_xor", lat, 16'h0000, 1'b1, 1'b1);

    launch(16'hFFFF, 16'h0001, SEL_ADD, 1'b0, 1'b1);
    wait_done(lat);
    expect_op("add_wrap", lat, 16'h0000, 1'b0, 1'b1);

    // Back-to-back: new start issued in the DONE cycle
    bus.a = 16'h1234; bus.b = 16'h0FFF; bus.select = SEL_ADD; bus.mode = 1'b0; bus.cin = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", 64'(bus.busy), 64'(1));
    wait_done(lat);
    expect_op("b2b_add", lat, 16'h2233, 1'b1, 1'b0);

    // Start pulse and operand changes while busy must be ignored
    launch(16'h0F0F, 16'h00F1, SEL_ADD, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.select = SEL_SUB;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat2);
    expect_op("ignored_start", lat2 + 2, 16'h1001, 1'b1, 1'b0);

    // Asynchronous reset two cycles into RUN
    launch(16'h00FF, 16'h0001, SEL_ADD, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy",   64'(bus.busy),   64'(0));
    check("midrst_done",   64'(bus.done),   64'(0));
    check("midrst_result", 64'(bus.result), 64'(0));
    check("midrst_cout",   64'(bus.cout),   64'(0));
    check("midrst_zero",   64'(bus.zero),   64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_seen++;
    end
    check("no_done_after_reset", 64'(done_seen), 64'(0));

    launch(16'h1234, 16'h0FFF, SEL_ADD, 1'b0, 1'b1);
    wait_done(lat);
    expect_op("post_reset_add", lat, 16'h2233, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
